// File: rtl/maria_line_ram.sv
// Maria double-buffered line RAM: byte queue, pixel serializer, read-and-clear port.
// Optional MARIA_KANGAROO_EN: kangaroo mode writes colour-00 pixels instead of skipping them.
module maria_line_ram #(
  parameter int LINE_W = 160,
  parameter int QDEPTH = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       mclk0,
  input  logic       lrc,
  input  logic       latch_byte,
  input  logic [7:0] DataB,
  input  logic [7:0] HPOS,
  input  logic       clear_hpos,
  input  logic       WM,
  input  logic [2:0] PAL,
  input  logic       kangaroo,
  input  logic       rd_en,
  input  logic [7:0] rd_hpos,
  input  logic       rd_clear,
  output logic [4:0] rd_pixel,
  output logic       busy,
  output logic       overflow
);

  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [7:0] LW = 8'(LINE_W);
  localparam logic [QW:0] QD = (QW + 1)'(QDEPTH);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t r_state, w_state_nx;

  logic [7:0] r_qb [QDEPTH];
  logic [7:0] r_qh [QDEPTH];
  logic [2:0] r_qpal [QDEPTH];
  logic       r_qwm [QDEPTH];
  logic       r_qld [QDEPTH];

  logic [4:0] r_ram0 [LINE_W];
  logic [4:0] r_ram1 [LINE_W];

  logic [QW-1:0] r_wptr, r_rptr, w_rptr1;
  logic [QW:0]   r_cnt;
  logic [7:0]    r_wp;
  logic [1:0]    r_pix;
  logic          r_lp, r_ovf, r_wbank, r_kang;

  logic       w_swap, w_push_req, w_full, w_push;
  logic       w_start, w_chain, w_done, w_last, w_kang;
  logic [7:0] w_hb, w_sh, w_ridx;
  logic [2:0] w_hpal, w_pal;
  logic       w_hwm;
  logic [1:0] w_col;
  logic       w_we, w_clr;
  logic       w_we0, w_we1;
  logic [7:0] w_a0, w_a1;
  logic [4:0] w_d0, w_d1, w_px, w_rdata;

  assign w_swap     = lrc & mclk0;
  assign w_push_req = latch_byte & mclk0 & ~w_swap;
  assign w_full     = (r_cnt == QD);
  assign w_push     = w_push_req & ~w_full;

  // The head entry stays queued until its last pixel is out.
  assign w_hb    = r_qb[r_rptr];
  assign w_hpal  = r_qpal[r_rptr];
  assign w_hwm   = r_qwm[r_rptr];
  assign w_rptr1 = r_rptr + 1'b1;
  assign w_last  = w_hwm ? (r_pix == 2'd1) : (r_pix == 2'd3);

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_chain    = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_cnt != '0) begin
          w_state_nx = S_EMIT;
          w_start    = 1'b1;
        end
      end
      S_EMIT: begin
        if (w_last) begin
          w_done = 1'b1;
          if (r_cnt > (QW + 1)'(1)) w_chain = 1'b1;
          else w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_sh = w_hb << {r_pix, 1'b0};

  always_comb begin
    w_col = w_sh[7:6];
    w_pal = w_hpal;
    if (w_hwm) begin
      w_col = r_pix[0] ? w_hb[1:0] : w_hb[3:2];
      w_pal = {w_hpal[2], r_pix[0] ? w_hb[5:4] : w_hb[7:6]};
    end
  end

`ifdef MARIA_KANGAROO_EN
  assign w_kang = r_kang;
`else
  assign w_kang = r_kang & kangaroo & 1'b0;
`endif

  assign w_px  = {w_pal, w_col};
  assign w_we  = (r_state == S_EMIT) & ~w_swap
               & ((w_col != 2'b00) | w_kang) & (r_wp < LW);
  assign w_ridx = (rd_hpos < LW) ? rd_hpos : 8'd0;
  assign w_clr  = rd_en & rd_clear & (rd_hpos < LW);

  assign w_we0 = r_wbank ? w_clr : w_we;
  assign w_a0  = r_wbank ? w_ridx : r_wp;
  assign w_d0  = r_wbank ? 5'd0 : w_px;
  assign w_we1 = r_wbank ? w_we : w_clr;
  assign w_a1  = r_wbank ? r_wp : w_ridx;
  assign w_d1  = r_wbank ? w_px : 5'd0;

  assign w_rdata = r_wbank ? r_ram0[w_ridx] : r_ram1[w_ridx];

  always_ff @(posedge clk_sys) begin
    if (w_we0) r_ram0[w_a0] <= w_d0;
    if (w_we1) r_ram1[w_a1] <= w_d1;
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_qb[r_wptr]   <= DataB;
      r_qh[r_wptr]   <= HPOS;
      r_qpal[r_wptr] <= PAL;
      r_qwm[r_wptr]  <= WM;
      r_qld[r_wptr]  <= r_lp;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_wp     <= 8'd0;
      r_pix    <= 2'd0;
      r_lp     <= 1'b0;
      r_ovf    <= 1'b0;
      r_wbank  <= 1'b0;
      r_kang   <= 1'b0;
      rd_pixel <= 5'd0;
    end else begin
      if (rd_en) rd_pixel <= (rd_hpos < LW) ? w_rdata : 5'd0;
      if (w_swap) begin
        r_wbank <= ~r_wbank;
        r_state <= S_IDLE;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_cnt   <= '0;
        r_pix   <= 2'd0;
        r_lp    <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        if (mclk0 & clear_hpos) r_lp <= 1'b1;
        else if (w_push_req) r_lp <= 1'b0;
        if (w_push_req & w_full) r_ovf <= 1'b1;
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_done) r_rptr <= w_rptr1;
        r_cnt   <= r_cnt + (QW + 1)'(w_push) - (QW + 1)'(w_done);
        r_state <= w_state_nx;
        if (w_start) begin
          r_pix  <= 2'd0;
          r_kang <= kangaroo;
          if (r_qld[r_rptr]) r_wp <= r_qh[r_rptr];
        end else if (w_chain) begin
          r_pix  <= 2'd0;
          r_kang <= kangaroo;
          r_wp   <= r_qld[w_rptr1] ? r_qh[w_rptr1] : r_wp + 8'd1;
        end else if (r_state == S_EMIT) begin
          r_pix <= r_pix + 2'd1;
          r_wp  <= r_wp + 8'd1;
        end
      end
    end
  end

  assign busy     = (r_cnt != '0) | (r_state == S_EMIT);
  assign overflow = r_ovf;

endmodule

// File: doc/maria_line_ram.md
Name: maria_line_ram

Overview:
- Downstream consumer of the Maria DMA controller.
- Accepts graphics bytes latched by DMA, together with the current HPOS, write mode (WM) and palette (PAL).
- Expands each byte into 2-bit-colour pixels and writes them into a double-buffered 160-entry line RAM.
- Serves the other bank to the pixel output stage with read-and-clear; banks swap at the line-RAM-change strobe (lrc).

Parameters:
- LINE_W, 160, visible pixel positions per bank; writes at or beyond this index are discarded.
- QDEPTH, 2, depth of the latched-byte queue (power of two).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- mclk0  in  1  Maria clock enable; qualifies latch_byte, clear_hpos and lrc
- lrc  in  1  line RAM swap strobe
- latch_byte  in  1  DMA graphics byte valid on DataB
- DataB  in  8  graphics byte
- HPOS  in  8  horizontal start position of the current object
- clear_hpos  in  1  new object header; next byte reloads the write pointer
- WM  in  1  write mode: 0 = 160A (4 px/byte), 1 = 160B (2 px/byte)
- PAL  in  3  object palette
- kangaroo  in  1  kangaroo mode (see Optional Feature)
- rd_en  in  1  display read strobe
- rd_hpos  in  8  display read index
- rd_clear  in  1  clear the read location after reading
- rd_pixel  out  5  {palette[2:0], colour[1:0]}, 1-cycle latency
- busy  out  1  queue non-empty or serializer active
- overflow  out  1  sticky: a byte was dropped because the queue was full

Behaviour:
- Reset values: rd_pixel=0, busy=0, overflow=0, bank select wbank=0, queue empty, serializer idle, load_pending=0, write pointer wp=0.
- RAM contents are undefined after reset; each location is cleared by a read with rd_clear.
- clear_hpos && mclk0 sets load_pending.
- latch_byte && mclk0 pushes the entry {DataB, WM, PAL, HPOS, load_pending} and clears load_pending.
  - Queue full on push: the entry is dropped and overflow is set.
- Serializer states:
  - IDLE: if the queue is non-empty, pop next cycle and go to EMIT. wp <= entry.HPOS when the entry's load flag is set.
  - EMIT: one pixel write per clk_sys cycle (not gated by mclk0). Count is 4 for WM=0, 2 for WM=1. wp increments by 1 after each pixel, 8-bit wrap 255->0.
  - After the last pixel: pop directly if the queue is non-empty, else go to IDLE.
- Latency from the latch cycle: first pixel is written 2 cycles later. For WM=0 the last pixel is written 5 cycles later.
- WM=0 pixel order: bits [7:6], [5:4], [3:2], [1:0]. Each pixel is stored as {PAL, colour}.
- WM=1 pixel 0: colour=byte[3:2], palette={PAL[2], byte[7:6]}.
- WM=1 pixel 1: colour=byte[1:0], palette={PAL[2], byte[5:4]}.
- Transparency: a pixel with colour==00 is skipped (no write) but still advances wp.
- Writes with wp >= LINE_W are suppressed; wp still advances.
- Writes target bank wbank; reads target bank ~wbank.
- Read path: rd_en samples ~wbank[rd_hpos] into rd_pixel on the next cycle.
  - rd_hpos >= LINE_W returns 0.
  - When rd_clear is also set, that location is written to 0 in the same cycle; no read/write conflict exists because the banks are separate.
- Swap: lrc && mclk0 toggles wbank, flushes the queue, forces the serializer to IDLE, clears load_pending and clears overflow.
  - A read issued in the swap cycle uses the pre-swap bank.
  - A push coinciding with lrc is discarded.
- rd_pixel holds its value when rd_en is low.

Optional Feature:
- Macro: MARIA_KANGAROO_EN.
- Defined: when kangaroo=1 at pop time, colour-00 pixels are written as {palette, 00}, i.e. not transparent.
- Undefined: transparency always applies; the kangaroo port remains but is ignored.

Test Plan:
- clear_hpos, then latch 0xE4 (WM=0, PAL=5, HPOS=10), lrc, read 10..13 -> 0x17, 0x16, 0x15, then 0 at 13 (transparent, never written after clear); busy high for exactly 5 cycles.
- WM=1, PAL=4, HPOS=20, byte 0x9E, swap, read 20/21 -> palette {1,10}=6, colour 11 -> 0x1B; palette {1,01}=5, colour 10 -> 0x16.
- HPOS=158, WM=0, byte 0xFF -> positions 158, 159 written with {PAL,11}; no writes at 160/161; wp wraps correctly from HPOS=254 to 0, 1.
- Three latches on consecutive mclk0 cycles with mclk0 held high -> first two bytes written, third dropped, overflow=1 until next lrc.
- Read with rd_clear at index 40, then same index after two swaps with no writes -> second read returns 0.
- With MARIA_KANGAROO_EN and kangaroo=1, byte 0x00 at HPOS=0, PAL=2 -> positions 0..3 read 0x08; without the macro they read the previously cleared value 0.
